// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_INC = 32'd4;

  // Fetch always proceeds at a word-aligned address.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq,
  input  logic         deq,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous enq and deq leave the occupancy unchanged.
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, fetch/redirect arbitration,
// misaligned-target flag, and the fetch FIFO feeding decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Instr_Addr,
  input  logic [31:0] Instr_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic         enq, deq, full, empty;
  fetch_entry_t wr_entry, rd_entry;

  assign deq = out_valid & out_ready;
  // A full FIFO that is draining this cycle still has room for the new word.
  assign enq = !redirect_valid & (!full | deq);

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q | (redirect_valid & (redirect_target[1:0] != 2'b00));
    if (redirect_valid) begin
      pc_d = align_pc(redirect_target);
    end else if (enq) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = Instr_rdata;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .enq    (enq),
    .deq    (deq),
    .flush  (redirect_valid),
    .wr_data(wr_entry),
    .rd_data(rd_entry),
    .full   (full),
    .empty  (empty)
  );

  assign Instr_Addr   = pc_q;
  assign out_valid    = !empty;
  assign out_instr    = rd_entry.instr;
  assign out_pc       = rd_entry.pc;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue of expected head PCs is
// filled by the stimulus and drained by a monitor on every decode handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instr_Addr;
  logic [31:0] Instr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] sb_q[$];

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Instr_Addr     (Instr_Addr),
    .Instr_rdata    (Instr_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_f = 32'h0080_02EF;
      32'h0000_0004: mem_f = 32'h0000_0013;
      32'h0000_0008: mem_f = 32'hFFDF_F06F;
      default:       mem_f = {a[15:0], ~a[15:0]};
    endcase
  endfunction

  assign Instr_rdata = mem_f(Instr_Addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out: got pc %h required no output", out_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          check("sb_pc", out_pc, exp_pc);
          check("sb_instr", out_instr, mem_f(exp_pc));
        end
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    out_ready       = 1'b1;
    fork
      monitor();
    join_none

    #3;
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_addr", Instr_Addr, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    tick();
    tick();

    // Streaming from reset release with decode always ready
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    sb_q.push_back(32'h8);
    rst_n = 1'b1;
    tick();
    check("t1_first_valid", {31'h0, out_valid}, 32'h1);
    check("t1_first_pc", out_pc, 32'h0);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    check("t1_drained", 32'(sb_q.size()), 32'h0);

    // Backpressure after reset, then release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t2_addr_hold", Instr_Addr, 32'h8);
    check("t2_valid", {31'h0, out_valid}, 32'h1);
    check("t2_head", out_pc, 32'h0);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    sb_q.push_back(32'h8);
    sb_q.push_back(32'hC);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check("t2_drained", 32'(sb_q.size()), 32'h0);

    // Redirect while full
    check("t3_full_valid", {31'h0, out_valid}, 32'h1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    tick();
    redirect_valid = 1'b0;
    check("t3_n1_valid", {31'h0, out_valid}, 32'h0);
    check("t3_n1_addr", Instr_Addr, 32'h10);
    tick();
    check("t3_n2_valid", {31'h0, out_valid}, 32'h1);
    check("t3_n2_pc", out_pc, 32'h10);
    sb_q.push_back(32'h10);
    sb_q.push_back(32'h14);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("t3_drained", 32'(sb_q.size()), 32'h0);

    // Misaligned redirect, sticky flag, back-to-back redirects
    check("t4_pre_misalign", {31'h0, misalign_err}, 32'h0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h22;
    tick();
    redirect_valid = 1'b0;
    check("t4_misalign_set", {31'h0, misalign_err}, 32'h1);
    check("t4_aligned_addr", Instr_Addr, 32'h20);
    tick();
    check("t4_pc", out_pc, 32'h20);
    check("t4_instr", out_instr, mem_f(32'h20));
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    check("t4_addr40", Instr_Addr, 32'h40);
    check("t4_sticky", {31'h0, misalign_err}, 32'h1);
    redirect_target = 32'h80;
    tick();
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t4_b2b_addr", Instr_Addr, 32'h100);
    check("t4_b2b_valid", {31'h0, out_valid}, 32'h0);
    tick();
    check("t4_b2b_pc", out_pc, 32'h100);
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h104);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("t4_drained", 32'(sb_q.size()), 32'h0);
    check("t4_sticky_end", {31'h0, misalign_err}, 32'h1);

    // PC wrap at the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t5_top_pc", out_pc, 32'hFFFF_FFFC);
    sb_q.push_back(32'hFFFF_FFFC);
    sb_q.push_back(32'h0);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("t5_drained", 32'(sb_q.size()), 32'h0);
    tick();
    check("t5_full_addr", Instr_Addr, 32'hC);
    check("t5_full_head", out_pc, 32'h4);

    // Asynchronous reset mid-cycle with two entries held
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", {31'h0, out_valid}, 32'h0);
    check("t6_addr", Instr_Addr, 32'h0);
    check("t6_pc", out_pc, 32'h0);
    check("t6_misalign", {31'h0, misalign_err}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_restart_valid", {31'h0, out_valid}, 32'h1);
    check("t6_restart_pc", out_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end feeding the instruction memory and the decode stage. Holds the program counter and drives the instruction-memory address. Captures each returned instruction word with its PC into a small FIFO. Presents the FIFO head to decode with a valid/ready handshake. Accepts redirects (branch/jump targets) from execute, which flush the FIFO.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
Instr_Addr  output  32  byte address to instruction memory; equals PC register.
Instr_rdata  input  32  instruction word from memory; combinational from Instr_Addr, same cycle.
redirect_valid  input  1  load new PC and flush this cycle.
redirect_target  input  32  new PC byte address.
out_valid  output  1  FIFO head valid.
out_ready  input  1  decode accepts head.
out_instr  output  32  head instruction word.
out_pc  output  32  PC of head instruction.
misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC; FIFO count=0; read/write pointers=0; misalign_err=0. Outputs: out_valid=0, out_instr=0, out_pc=0 (head storage cleared), Instr_Addr=RESET_PC.
- FIFO state: count 0..DEPTH, wr_ptr and rd_ptr of clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- deq = out_valid & out_ready.
- enq = !redirect_valid & (count<DEPTH | deq). Full-with-dequeue still enqueues the same cycle.
- On enq at clock edge:
  - entry[wr_ptr] <= {Instr_Addr, Instr_rdata}.
  - wr_ptr++.
  - pc <= pc+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- On deq: rd_ptr++.
- count update: +1 on enq only; -1 on deq only; unchanged on both.
- When full with no deq: pc holds and Instr_Addr is stable. No entry is lost or duplicated.
- On redirect_valid at edge:
  - count=0, wr_ptr=rd_ptr=0.
  - pc <= {redirect_target[31:2],2'b00}.
  - No enqueue that cycle.
  - Redirect overrides a simultaneous deq. Decode may consume the head shown that cycle, but the block does not track that consumption.
- Misaligned redirect: if redirect_target[1:0]!=0, set misalign_err=1. It stays set until reset, and the fetch proceeds at the aligned address.
- Latency:
  - Redirect asserted in cycle N: Instr_Addr=target in N+1; out_valid=1 with out_pc=target in N+2.
  - After reset release: first entry visible one cycle after the first rising edge.
- Steady state with out_ready=1: one instruction per cycle, out_pc increasing by 4.
- out_valid = (count!=0). out_instr/out_pc come from entry[rd_ptr], registered storage with combinational mux and no bypass. Contents are don't-care when out_valid=0 after the first fill.
- Back-to-back redirects: each flushes; only the last target is fetched.
- Reset asserted mid-stream: immediate clear, no partial state retained.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}.
  - localparam PC_INC=4.
- One sub-module: fetch_fifo (parameterised DEPTH, fetch_entry_t storage, enq/deq/flush, count, full/empty).
- Top fetch_unit holds the pc register, enq/redirect arbitration and the misalign flag.

Test Plan:
1. Reset release, memory words 0/4/8 = 32'h008002EF/32'h00000013/32'hFFDFF06F, out_ready=1 -> out_pc 0,4,8 on consecutive cycles starting one cycle after release; out_instr matches.
2. out_ready=0 for 5 cycles after reset -> count saturates at 2, Instr_Addr holds at 8. Raise ready -> out_pc 0,4,8,12 with no gap or duplicate.
3. Redirect to 32'h10 in cycle N while FIFO full -> out_valid=0 in N+1, out_pc=32'h10 in N+2, old entries never appear.
4. Redirect to 32'h0000_0022 -> misalign_err=1 from next cycle, fetch resumes at 32'h20. Flag stays 1 after further aligned redirects until rst_n pulse.
5. Redirect to 32'hFFFF_FFFC, ready=1 -> out_pc FFFF_FFFC then 0000_0000.
6. rst_n asserted asynchronously mid-cycle with FIFO holding 2 entries -> out_valid=0 and Instr_Addr=RESET_PC immediately, without waiting for a clock edge.
